scan_capture: RTL and testbench

SCAN_CAPTURE -- requirements
Module: scan_capture

---
 rtl/scan_capture.sv | 155 +++++++++++++++
 tb/tb_scan_capture.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_capture.sv
// Captures an eight-digit frame from a multiplexed display bus (active-low digit strobes plus BCD value)
// and publishes it atomically once all digits arrived in order without a strobe, sequence or range error.
module scan_capture #(
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ani_in,
   input  logic [3:0]  bcd_in,
   output logic [31:0] digits_out,
   output logic        frame_valid,
   output logic        locked,
   output logic        seq_err,
   output logic        strobe_err,
   output logic        range_err,
   output logic [7:0]  err_count
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic {S_HUNT, S_CAPTURE} state_t;

   state_t          r_state;
   logic [7:0]      r_ani;
   logic [3:0]      r_bcd;
   logic [3:0]      r_shadow [8];
   logic [2:0]      r_last;
   logic            r_bad;
   logic            r_pub;
   logic [CW-1:0]   r_idle_cnt;

   logic            w_idle;
   logic            w_valid;
   logic [2:0]      w_idx;
   logic [2:0]      w_last_inc;
   logic            w_over9;
   logic            w_same;
   logic            w_next;
   logic            w_seq_nx;
   logic            w_strobe_nx;
   logic            w_range_nx;
   logic [8:0]      w_err_sum;
   logic [31:0]     w_shadow_flat;

   always_comb begin
      w_idx = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (!r_ani[k]) w_idx = 3'(k);
      end
      for (int k = 0; k < 8; k++) begin
         w_shadow_flat[4*k +: 4] = r_shadow[k];
      end
   end

   assign w_idle      = (r_ani == 8'hFF);
   assign w_valid     = ($countones(~r_ani) == 1);
   assign w_last_inc  = r_last + 3'd1;
   assign w_over9     = (r_bcd > 4'd9);
   assign w_same      = (w_idx == r_last);
   assign w_next      = (w_idx == w_last_inc);

   // Error pulses are decoded combinationally so err_count moves on the same edge as the pulses.
   assign w_strobe_nx = !w_valid && !w_idle;
   assign w_seq_nx    = (r_state == S_CAPTURE) && w_valid && !w_same && !w_next;
   assign w_range_nx  = w_valid && w_over9 &&
                        ((w_idx == 3'd0) || ((r_state == S_CAPTURE) && (w_same || w_next)));
   assign w_err_sum   = {1'b0, err_count} + 9'(w_seq_nx) + 9'(w_strobe_nx) + 9'(w_range_nx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_HUNT;
         r_ani       <= 8'hFF;
         r_bcd       <= 4'd0;
         for (int k = 0; k < 8; k++) r_shadow[k] <= 4'd0;
         r_last      <= 3'd0;
         r_bad       <= 1'b0;
         r_pub       <= 1'b0;
         r_idle_cnt  <= '0;
         digits_out  <= 32'd0;
         frame_valid <= 1'b0;
         locked      <= 1'b0;
         seq_err     <= 1'b0;
         strobe_err  <= 1'b0;
         range_err   <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         r_ani       <= ani_in;
         r_bcd       <= bcd_in;
         r_pub       <= 1'b0;
         frame_valid <= r_pub;
         seq_err     <= w_seq_nx;
         strobe_err  <= w_strobe_nx;
         range_err   <= w_range_nx;
         err_count   <= (w_err_sum > 9'd255) ? 8'hFF : w_err_sum[7:0];

         // A completed clean frame always leaves the FSM in HUNT, so nothing below overrides locked here.
         if (r_pub) begin
            digits_out <= w_shadow_flat;
            locked     <= 1'b1;
         end

         case (r_state)
            S_HUNT: begin
               r_idle_cnt <= '0;
               if (w_valid && w_idx == 3'd0) begin
                  r_shadow[0] <= r_bcd;
                  r_last      <= 3'd0;
                  r_bad       <= w_over9;
                  r_state     <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (w_valid) begin
                  r_idle_cnt <= '0;
                  if (w_same) begin
                     r_shadow[w_idx] <= r_bcd;
                     r_bad           <= r_bad | w_over9;
                  end else if (w_next) begin
                     r_shadow[w_idx] <= r_bcd;
                     r_bad           <= r_bad | w_over9;
                     r_last          <= w_idx;
                     if (w_idx == 3'd7) begin
                        r_state <= S_HUNT;
                        if (r_bad || w_over9) locked <= 1'b0;
                        else                  r_pub  <= 1'b1;
                     end
                  end else begin
                     locked <= 1'b0;
                     if (w_idx == 3'd0) begin
                        r_shadow[0] <= r_bcd;
                        r_last      <= 3'd0;
                        r_bad       <= w_over9;
                     end else begin
                        r_state <= S_HUNT;
                     end
                  end
               end else if (w_idle) begin
                  if (r_idle_cnt == CW'(TIMEOUT - 1)) begin
                     r_idle_cnt <= '0;
                     r_state    <= S_HUNT;
                     locked     <= 1'b0;
                  end else begin
                     r_idle_cnt <= r_idle_cnt + 1'b1;
                  end
               end else begin
                  locked  <= 1'b0;
                  r_state <= S_HUNT;
               end
            end
            default: r_state <= S_HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_scan_capture.sv
// Scoreboard bench for scan_capture: expected frames are queued as scans are driven and
// popped whenever frame_valid is seen; error pulses are tallied per cycle.
module tb_scan_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ani_in;
   logic [3:0]  bcd_in;
   logic [31:0] digits_out;
   logic        frame_valid, locked, seq_err, strobe_err, range_err;
   logic [7:0]  err_count;

   int          checks = 0;
   int          errors = 0;
   int          fv_cnt = 0, seq_cnt = 0, strb_cnt = 0, rng_cnt = 0;
   int          exp_err = 0;
   logic [31:0] last_frame = 32'd0;
   logic [31:0] exp_q [$];

   scan_capture #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .ani_in(ani_in), .bcd_in(bcd_in),
      .digits_out(digits_out), .frame_valid(frame_valid), .locked(locked),
      .seq_err(seq_err), .strobe_err(strobe_err), .range_err(range_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   // One clock: inputs applied on the falling edge, outputs sampled on the next falling edge.
   task automatic cyc(input logic [7:0] a, input logic [3:0] b);
      logic [31:0] e;
      ani_in = a;
      bcd_in = b;
      @(posedge clk);
      @(negedge clk);
      if (frame_valid) begin
         fv_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: digits_out=%h with no frame expected", digits_out);
         end else begin
            e = exp_q.pop_front();
            last_frame = e;
            if (digits_out !== e) begin
               errors++;
               $display("FAIL frame_data: digits_out=%h expected %h", digits_out, e);
            end
         end
         $display("frame: digits_out=%h", digits_out);
      end
      if (seq_err)    seq_cnt++;
      if (strobe_err) strb_cnt++;
      if (range_err)  rng_cnt++;
   endtask

   task automatic strobe(input int idx, input logic [3:0] v);
      logic [7:0] a;
      a = 8'hFF;
      a[idx] = 1'b0;
      cyc(a, v);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(8'hFF, 4'd0);
   endtask

   // Drives a full eight-digit scan from a packed value and queues it when it should publish.
   task automatic scan(input logic [31:0] d, input bit expect_pub);
      if (expect_pub) exp_q.push_back(d);
      for (int k = 0; k < 8; k++) strobe(k, d[4*k +: 4]);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("check %s: %h", name, act);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; ani_in = 8'hFF; bcd_in = 4'd0;
      #1;
      chk("reset_digits", digits_out, 32'd0);
      repeat (2) @(negedge clk);
      chk("reset_flags", {28'd0, frame_valid, seq_err, strobe_err, range_err}, 32'd0);
      chk("reset_locked", {31'd0, locked}, 32'd0);
      chk("reset_errcnt", {24'd0, err_count}, 32'd0);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_clean_scan;
      int fv0;
      fv0 = fv_cnt;
      scan(32'h87654321, 1'b1);
      idle(3);
      chk("clean_frames", fv_cnt - fv0, 1);
      chk("clean_digits", digits_out, 32'h87654321);
      chk("clean_locked", {31'd0, locked}, 32'd1);
      chk("clean_errcnt", {24'd0, err_count}, 32'(exp_err));
   endtask

   task automatic test_held;
      int fv0;
      int e0;
      logic [3:0] v;
      fv0 = fv_cnt;
      e0  = seq_cnt + strb_cnt + rng_cnt;
      exp_q.push_back(32'h09090909);
      for (int k = 0; k < 8; k++) begin
         v = (k % 2 == 0) ? 4'd9 : 4'd0;
         repeat (3) strobe(k, v);
      end
      idle(3);
      chk("held_frames", fv_cnt - fv0, 1);
      chk("held_digits", digits_out, 32'h09090909);
      chk("held_errpulses", seq_cnt + strb_cnt + rng_cnt - e0, 0);
      chk("held_errcnt", {24'd0, err_count}, 32'(exp_err));
   endtask

   task automatic test_seq_err;
      int fv0;
      int s0;
      fv0 = fv_cnt;
      s0  = seq_cnt;
      strobe(0, 4'd1); strobe(1, 4'd2); strobe(2, 4'd3); strobe(4, 4'd5);
      idle(2);
      exp_err += 1;
      chk("seq_pulses", seq_cnt - s0, 1);
      chk("seq_frames", fv_cnt - fv0, 0);
      chk("seq_locked", {31'd0, locked}, 32'd0);
      chk("seq_errcnt", {24'd0, err_count}, 32'(exp_err));
      scan(32'h12345678, 1'b1);
      idle(3);
      chk("seq_recover_frames", fv_cnt - fv0, 1);
      chk("seq_recover_locked", {31'd0, locked}, 32'd1);
   endtask

   task automatic test_strobe_err;
      int fv0;
      int t0;
      fv0 = fv_cnt;
      t0  = strb_cnt;
      strobe(0, 4'd1); strobe(1, 4'd1); strobe(2, 4'd1);
      cyc(8'b11111100, 4'd1);
      idle(2);
      exp_err += 1;
      chk("strobe_pulses", strb_cnt - t0, 1);
      chk("strobe_locked", {31'd0, locked}, 32'd0);
      chk("strobe_errcnt", {24'd0, err_count}, 32'(exp_err));
      for (int k = 3; k < 8; k++) strobe(k, 4'd2);
      idle(3);
      chk("strobe_hunt_frames", fv_cnt - fv0, 0);
      chk("strobe_hunt_digits", digits_out, last_frame);
   endtask

   task automatic test_range;
      int fv0;
      int r0;
      scan(32'h76543210, 1'b1);
      idle(3);
      chk("range_pre_locked", {31'd0, locked}, 32'd1);
      fv0 = fv_cnt;
      r0  = rng_cnt;
      scan(32'h23C45678, 1'b0);
      idle(3);
      exp_err += 1;
      chk("range_pulses", rng_cnt - r0, 1);
      chk("range_frames", fv_cnt - fv0, 0);
      chk("range_digits", digits_out, 32'h76543210);
      chk("range_locked", {31'd0, locked}, 32'd0);
      chk("range_errcnt", {24'd0, err_count}, 32'(exp_err));
   endtask

   task automatic test_back_to_back;
      int fv0;
      fv0 = fv_cnt;
      scan(32'h33333333, 1'b1);
      scan(32'h01234567, 1'b1);
      idle(3);
      chk("b2b_frames", fv_cnt - fv0, 2);
      chk("b2b_digits", digits_out, 32'h01234567);
      chk("b2b_locked", {31'd0, locked}, 32'd1);
   endtask

   task automatic test_timeout_and_reset;
      int fv0;
      int e0;
      fv0 = fv_cnt;
      e0  = seq_cnt + strb_cnt + rng_cnt;
      for (int k = 0; k < 4; k++) strobe(k, 4'd4);
      idle(4);
      chk("timeout_locked_before", {31'd0, locked}, 32'd1);
      idle(1);
      chk("timeout_locked_after", {31'd0, locked}, 32'd0);
      chk("timeout_errpulses", seq_cnt + strb_cnt + rng_cnt - e0, 0);
      for (int k = 4; k < 8; k++) strobe(k, 4'd4);
      idle(3);
      chk("timeout_hunt_frames", fv_cnt - fv0, 0);
      scan(32'h55443322, 1'b1);
      idle(3);
      chk("timeout_recover_locked", {31'd0, locked}, 32'd1);
      for (int k = 0; k < 4; k++) strobe(k, 4'd6);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_digits", digits_out, 32'd0);
      chk("async_rst_locked", {31'd0, locked}, 32'd0);
      chk("async_rst_errcnt", {24'd0, err_count}, 32'd0);
      exp_err = 0;
      last_frame = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      fv0 = fv_cnt;
      for (int k = 4; k < 8; k++) strobe(k, 4'd6);
      idle(3);
      chk("rst_partial_frames", fv_cnt - fv0, 0);
      chk("rst_partial_digits", digits_out, 32'd0);
      scan(32'h98765432, 1'b1);
      idle(3);
      chk("rst_resume_frames", fv_cnt - fv0, 1);
   endtask

   task automatic test_double_err;
      int s0;
      int r0;
      s0 = seq_cnt;
      r0 = rng_cnt;
      strobe(0, 4'd1); strobe(1, 4'd1); strobe(0, 4'hC);
      idle(6);
      exp_err += 2;
      chk("double_seq", seq_cnt - s0, 1);
      chk("double_range", rng_cnt - r0, 1);
      chk("double_errcnt", {24'd0, err_count}, 32'(exp_err));
   endtask

   task automatic test_saturate;
      int t0;
      t0 = strb_cnt;
      for (int i = 0; i < 300; i++) cyc(8'h00, 4'd0);
      idle(2);
      exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
      chk("sat_pulses", strb_cnt - t0, 300);
      chk("sat_errcnt", {24'd0, err_count}, 32'(exp_err));
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      test_reset;
      test_clean_scan;
      test_held;
      test_seq_err;
      test_strobe_err;
      test_range;
      test_back_to_back;
      test_timeout_and_reset;
      test_double_err;
      test_saturate;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
